// File: rtl/uart_rx_packet_ctrl_if.sv
// rtl/uart_rx_packet_ctrl_if.sv - byte-stream, packet handshake and read-port bundle for uart_rx_packet_ctrl
//   Rx_DataValid/Rx_Byte : byte strobe from the UART receiver
//   Pkt_Valid/Pkt_Ready  : held-packet handshake, Pkt_Len its payload length
//   Rd_Addr/Rd_Data      : combinational random read of the held payload
//   Pkt_Error/Err_Code   : one-cycle reject pulse and its held cause code
//   master = byte source / packet consumer, slave = the frame controller
interface uart_rx_packet_ctrl_if;
    logic       Rx_DataValid;
    logic [7:0] Rx_Byte;
    logic       Pkt_Valid;
    logic       Pkt_Ready;
    logic [7:0] Pkt_Len;
    logic [7:0] Rd_Addr;
    logic [7:0] Rd_Data;
    logic       Pkt_Error;
    logic [1:0] Err_Code;

    modport master (
        output Rx_DataValid, Rx_Byte, Pkt_Ready, Rd_Addr,
        input  Pkt_Valid, Pkt_Len, Rd_Data, Pkt_Error, Err_Code
    );

    modport slave (
        input  Rx_DataValid, Rx_Byte, Pkt_Ready, Rd_Addr,
        output Pkt_Valid, Pkt_Len, Rd_Data, Pkt_Error, Err_Code
    );
endinterface

// File: rtl/uart_rx_packet_ctrl.sv
// rtl/uart_rx_packet_ctrl.sv - SOF/LEN/payload/checksum frame controller behind the UART receiver
//   Master_Clk   : sole clock, posedge
//   Master_Reset : synchronous active-high reset
//   bus          : uart_rx_packet_ctrl_if.slave (byte stream in, packet handshake/read port/error out)
//   UART_PKT_TIMEOUT_EN : when defined, adds the inter-byte timeout (error code 11)
module uart_rx_packet_ctrl #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CLKS = 3200
) (
    input logic                  Master_Clk,
    input logic                  Master_Reset,
    uart_rx_packet_ctrl_if.slave bus
);

    localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_BADLEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_HOLD} state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] idx, idx_n;
    logic [7:0] sum, sum_n;
    logic [7:0] len_q, len_n;
    logic       err_q, err_n;
    logic [1:0] code_q, code_n;
    logic       wr_en;
    logic       timer_exp;

    logic [7:0] mem [0:MAX_LEN-1];

    logic       dv;
    logic [7:0] rx;
    assign dv = bus.Rx_DataValid;
    assign rx = bus.Rx_Byte;

`ifdef UART_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] timer;
    logic          in_frame;

    assign in_frame  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    // A strobe in the expiry cycle is handled as a byte, never as a timeout.
    assign timer_exp = in_frame && !dv && (timer == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge Master_Clk) begin
        if (Master_Reset || dv || !in_frame) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end
`else
    assign timer_exp = 1'b0;
`endif

    always_ff @(posedge Master_Clk) begin
        if (Master_Reset) begin
            state  <= S_IDLE;
            cnt    <= 8'h00;
            idx    <= 8'h00;
            sum    <= 8'h00;
            len_q  <= 8'h00;
            err_q  <= 1'b0;
            code_q <= ERR_OVERRUN;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            sum    <= sum_n;
            len_q  <= len_n;
            err_q  <= err_n;
            code_q <= code_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sum_n   = sum;
        len_n   = len_q;
        err_n   = 1'b0;
        code_n  = code_q;
        wr_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (dv && rx == SOF_BYTE) state_n = S_LEN;
            end
            S_LEN: begin
                if (dv) begin
                    if (rx == 8'h00 || rx > MAX_LEN_B) begin
                        err_n   = 1'b1;
                        code_n  = ERR_BADLEN;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n   = rx;
                        sum_n   = rx;
                        idx_n   = 8'h00;
                        state_n = S_PAYLOAD;
                    end
                end else if (timer_exp) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (dv) begin
                    wr_en = 1'b1;
                    idx_n = idx + 8'h01;
                    sum_n = sum + rx;
                    if (idx_n == cnt) state_n = S_CSUM;
                end else if (timer_exp) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = S_IDLE;
                end
            end
            S_CSUM: begin
                if (dv) begin
                    if (rx == sum) begin
                        len_n   = cnt;
                        state_n = S_HOLD;
                    end else begin
                        err_n   = 1'b1;
                        code_n  = ERR_CSUM;
                        state_n = S_IDLE;
                    end
                end else if (timer_exp) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = S_IDLE;
                end
            end
            S_HOLD: begin
                // The buffer is frozen while held, so any incoming byte is lost.
                if (dv) begin
                    err_n  = 1'b1;
                    code_n = ERR_OVERRUN;
                end
                if (bus.Pkt_Ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // idx < cnt <= MAX_LEN during PAYLOAD, so the truncated index stays in range.
    always_ff @(posedge Master_Clk) begin
        if (wr_en) mem[idx[IW-1:0]] <= rx;
    end

    assign bus.Pkt_Valid = (state == S_HOLD);
    assign bus.Pkt_Len   = len_q;
    assign bus.Pkt_Error = err_q;
    assign bus.Err_Code  = code_q;
    assign bus.Rd_Data   = (bus.Rd_Addr < len_q) ? mem[bus.Rd_Addr[IW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// tb/tb_uart_rx_packet_ctrl.sv - directed and randomized checks of uart_rx_packet_ctrl against a frame-level model
module tb_uart_rx_packet_ctrl;

    localparam int MAX_LEN  = 16;
    localparam int TIMEOUT  = 3200;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_packet_ctrl_if ifc ();

    uart_rx_packet_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .SOF_BYTE    (8'hA5),
        .TIMEOUT_CLKS(TIMEOUT)
    ) dut (
        .Master_Clk  (clk),
        .Master_Reset(rst),
        .bus         (ifc)
    );

    int         tests = 0;
    int         fails = 0;
    int         err_seen = 0;
    logic [1:0] err_last = 2'b00;
    int         overlap = 0;
    logic       pv_d = 1'b0;

    always @(negedge clk) begin
        if (ifc.Pkt_Error) begin
            err_seen = err_seen + 1;
            err_last = ifc.Err_Code;
        end
        if (ifc.Pkt_Error && ifc.Pkt_Valid && !pv_d) overlap = overlap + 1;
        pv_d = ifc.Pkt_Valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        ifc.Rx_DataValid = 1'b1;
        ifc.Rx_Byte      = b;
        step(1);
        ifc.Rx_DataValid = 1'b0;
    endtask

    task automatic send_q(input byte_q_t q);
        foreach (q[i]) send(q[i]);
    endtask

    // Reference: checksum is the mod-256 sum of the length byte and every payload byte.
    function automatic logic [7:0] csum_of(input byte_q_t pl);
        int s;
        s = pl.size();
        foreach (pl[i]) s = s + int'(pl[i]);
        return 8'(s % 256);
    endfunction

    task automatic check_pkt(input string tag, input byte_q_t pl);
        chk({tag, "_valid"}, ifc.Pkt_Valid, 1);
        chk({tag, "_len"}, ifc.Pkt_Len, pl.size());
        for (int a = 0; a <= pl.size(); a++) begin
            ifc.Rd_Addr = 8'(a);
            #1;
            chk($sformatf("%s_rd%0d", tag, a), ifc.Rd_Data, (a < pl.size()) ? pl[a] : 8'h00);
        end
        ifc.Rd_Addr = 8'hFF;
        #1;
        chk({tag, "_rd_ff"}, ifc.Rd_Data, 8'h00);
    endtask

    task automatic release_pkt(input string tag);
        ifc.Pkt_Ready = 1'b1;
        step(1);
        ifc.Pkt_Ready = 1'b0;
        chk({tag, "_released"}, ifc.Pkt_Valid, 0);
    endtask

    initial begin
        int e0;
        int hit;
        int lat;
        byte_q_t pl;
        byte_q_t fr;

        ifc.Rx_DataValid = 1'b0;
        ifc.Rx_Byte      = 8'h00;
        ifc.Pkt_Ready    = 1'b0;
        ifc.Rd_Addr      = 8'h00;
        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_valid", ifc.Pkt_Valid, 0);
        chk("rst_error", ifc.Pkt_Error, 0);
        chk("rst_code", ifc.Err_Code, 0);
        chk("rst_len", ifc.Pkt_Len, 0);

        // Basic frame, including the one-cycle valid latency.
        e0 = err_seen;
        send_q('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33});
        chk("t1_not_yet_valid", ifc.Pkt_Valid, 0);
        send(8'h69);
        chk("t1_valid_latency", ifc.Pkt_Valid, 1);
        check_pkt("t1", '{8'h11, 8'h22, 8'h33});
        step(1);
        chk("t1_no_err", err_seen - e0, 0);
        release_pkt("t1");

        // Leading junk before SOF.
        e0 = err_seen;
        send_q('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F});
        check_pkt("t2", '{8'h7E});
        step(1);
        chk("t2_no_err", err_seen - e0, 0);
        release_pkt("t2");

        // Overrun while held, then overrun on the release cycle itself.
        pl = '{8'hAA, 8'h55};
        send_q('{8'hA5, 8'h02, 8'hAA, 8'h55, csum_of(pl)});
        e0 = err_seen;
        send(8'h55);
        step(1);
        chk("t4_err_count", err_seen - e0, 1);
        chk("t4_err_code", err_last, 0);
        check_pkt("t4_held", pl);
        e0 = err_seen;
        ifc.Pkt_Ready = 1'b1;
        send(8'h12);
        ifc.Pkt_Ready = 1'b0;
        chk("t4_rel_valid", ifc.Pkt_Valid, 0);
        step(1);
        chk("t4_rel_err_count", err_seen - e0, 1);
        chk("t4_rel_err_code", err_last, 0);

        // Stalled partial frame.
        e0 = err_seen;
        send_q('{8'hA5, 8'h02, 8'h10});
`ifdef UART_PKT_TIMEOUT_EN
        hit = 0;
        lat = 0;
        for (int i = 1; i <= TIMEOUT + 200; i++) begin
            step(1);
            if (ifc.Pkt_Error) begin
                hit = 1;
                lat = i;
                break;
            end
        end
        chk("t5_timeout_fired", hit, 1);
        chk("t5_timeout_code", ifc.Err_Code, 3);
        chk("t5_timeout_window", (lat >= TIMEOUT - 5 && lat <= TIMEOUT + 5), 1);
        send_q('{8'hA5, 8'h01, 8'h05, 8'h06});
        check_pkt("t5_after", '{8'h05});
        release_pkt("t5");
`else
        step(TIMEOUT + 100);
        chk("t5_no_timeout", err_seen - e0, 0);
        send_q('{8'h20, 8'h32});
        check_pkt("t5_resumed", '{8'h10, 8'h20});
        release_pkt("t5");
`endif

        // Checksum and length rejects.
        e0 = err_seen;
        send_q('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
        chk("t3_csum_valid", ifc.Pkt_Valid, 0);
        step(1);
        chk("t3_csum_count", err_seen - e0, 1);
        chk("t3_csum_code", err_last, 2);
        send_q('{8'hA5, 8'h00});
        step(1);
        chk("t3_len0_count", err_seen - e0, 2);
        chk("t3_len0_code", err_last, 1);
        send_q('{8'hA5, 8'h11});
        step(1);
        chk("t3_len17_count", err_seen - e0, 3);
        chk("t3_len17_code", err_last, 1);
        chk("t3_len17_valid", ifc.Pkt_Valid, 0);

        // Reset in the middle of a frame.
        send_q('{8'hA5, 8'h02, 8'h10});
        e0 = err_seen;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_valid", ifc.Pkt_Valid, 0);
        chk("t6_error", ifc.Pkt_Error, 0);
        chk("t6_code", ifc.Err_Code, 0);
        chk("t6_len", ifc.Pkt_Len, 0);
        step(2);
        chk("t6_no_err", err_seen - e0, 0);
        send_q('{8'hA5, 8'h01, 8'h05, 8'h06});
        check_pkt("t6_after", '{8'h05});
        release_pkt("t6");

        // Randomized frames against the reference checksum.
        for (int n = 0; n < 24; n++) begin
            int  len;
            bit  bad;
            logic [7:0] cs;
            len = (n == 0) ? MAX_LEN : (n == 1) ? 1 : int'($urandom_range(1, MAX_LEN));
            bad = (n > 1) && ($urandom_range(0, 3) == 0);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
            cs = csum_of(pl);
            if (bad) cs = cs + 8'($urandom_range(1, 255));
            fr.delete();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                logic [7:0] jb;
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                fr.push_back(jb);
            end
            fr.push_back(8'hA5);
            fr.push_back(8'(len));
            foreach (pl[i]) fr.push_back(pl[i]);
            fr.push_back(cs);
            e0 = err_seen;
            foreach (fr[i]) begin
                send(fr[i]);
                if (i < fr.size() - 1) step($urandom_range(0, 3));
            end
            if (bad) begin
                chk($sformatf("rnd%0d_valid", n), ifc.Pkt_Valid, 0);
                step(1);
                chk($sformatf("rnd%0d_err", n), err_seen - e0, 1);
                chk($sformatf("rnd%0d_code", n), err_last, 2);
            end else begin
                check_pkt($sformatf("rnd%0d", n), pl);
                step(1);
                chk($sformatf("rnd%0d_noerr", n), err_seen - e0, 0);
                release_pkt($sformatf("rnd%0d", n));
            end
        end

        chk("no_error_with_valid_rise", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
